apb_arbiter: RTL
================

# apb_arbiter

Shares a single APB master port between `NREQ` local requesters, such as the test sequencer, a DMA engine and a register-init engine. It performs round-robin arbitration and runs the APB SETUP/ACCESS protocol on behalf of the granted requester. Each completed transfer is returned to its owner with read data and an error flag. An optional PREADY watchdog aborts transfers to a hung slave.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `AW`, default 32: PADDR width.
- `DW`, default 32: PWDATA/PRDATA width.
- `TIMEOUT`, default 16: maximum consecutive ACCESS cycles with PREADY low before abort. 0 disables the watchdog.

Ports:
- `PCLK` in 1: the only clock; all logic on its rising edge.
- `PRESET` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: request per requester. Sampled only in IDLE.
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*AW: requester i occupies `[i*AW +: AW]`.
- `req_wdata` in NREQ*DW: requester i occupies `[i*DW +: DW]`.
- `req_ready` out NREQ: one-hot, one-cycle pulse marking the request as accepted.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse marking the transfer as finished.
- `rsp_rdata` out DW: read data, valid with `rsp_valid`.
- `rsp_err` out 1: PSLVERR or timeout, valid with `rsp_valid`.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB master controls.
- `PADDR` out AW, `PWDATA` out DW: APB master address and write data.
- `PRDATA` in DW, `PREADY` in 1, `PSLVERR` in 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE:**
  - Arbitration: when any `req_valid` bit is set, grant the first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - On grant: `last` ← grant index. Latch that requester's addr, write and wdata into PADDR/PWRITE/PWDATA. Next state is SETUP.
- **SETUP:** PSEL=1, PENABLE=0, `req_ready[g]`=1 for this cycle only. Next state is ACCESS unconditionally.
- **ACCESS:** PSEL=1, PENABLE=1.
  - PREADY=1 at an edge: transfer completes. Next state is IDLE, PSEL=PENABLE=0. During the following cycle:
    - `rsp_valid[g]`=1.
    - `rsp_err` = sampled PSLVERR.
    - `rsp_rdata` = sampled PRDATA for a read, 0 for a write.
  - PREADY=0: the wait counter increments.
  - Watchdog: when TIMEOUT≠0 and the counter reaches TIMEOUT (PREADY low for TIMEOUT consecutive ACCESS edges), abort.
    - Next state is IDLE, PSEL=PENABLE=0.
    - `rsp_valid[g]`=1, `rsp_err`=1, `rsp_rdata`=0.
  - The counter clears on every entry to SETUP. Its width is clog2(TIMEOUT+1).
- PADDR, PWRITE and PWDATA hold their last values between transfers. `rsp_rdata` and `rsp_err` hold their values until the next response.
- Requester obligations:
  - Hold addr/write/wdata stable from `req_valid` rise until `req_ready`.
  - Drop `req_valid` after `req_ready` unless it issues another transfer. A request still high when the arbiter returns to IDLE is treated as a new request.
- Only one transfer is outstanding at a time; there is no pipelining across transfers.

## Timing
- **Reset values:** PRESET=1 asynchronously forces the following, with no `rsp_valid` for an aborted transfer:
  - state IDLE;
  - all outputs 0;
  - `last`=NREQ-1, so requester 0 wins first;
  - wait counter 0.
- **Request in IDLE, cycle 0:**
  - SETUP in cycle 1.
  - ACCESS from cycle 2.
  - With PREADY=1 in cycle 2 (zero-wait slave), `rsp_valid` appears in cycle 3 and the arbiter is back in IDLE in cycle 3.
  - Minimum transfer period is 3 cycles, because IDLE lasts at least one cycle between transfers.
- Each wait state adds one cycle.
- A request arriving during SETUP or ACCESS is only seen at the next IDLE cycle.
- Simultaneous requests: round-robin guarantees each of N continuously requesting requesters a grant within N transfers.
- PREADY and PSLVERR are ignored outside ACCESS.
- If PREADY rises on the same edge where the counter would reach TIMEOUT, the transfer completes normally and no timeout is reported.
- PRESET deasserts synchronously to PCLK at the board level. The first grant can occur on the first edge after deassertion.

## Test plan
- **Single write, zero-wait:** `req_valid[0]`, addr 0x0001_0004, wdata 0xA5A5_0001, in cycle 0.
  - Cycle 1: PSEL=1, PENABLE=0, PWRITE=1, PADDR=0x00010004, `req_ready`=0001.
  - Cycle 2: PENABLE=1.
  - Cycle 3: `rsp_valid`=0001, `rsp_err`=0.
- **Read with 2 wait states:** `req_valid[2]`, addr 0x20. Slave holds PREADY low for 2 ACCESS cycles, then returns PRDATA=0xDEAD_BEEF.
  - ACCESS lasts 3 cycles.
  - `rsp_valid`=0100, `rsp_rdata`=0xDEADBEEF.
- **Round-robin:** all four `req_valid` held high, each dropped after its `req_ready`.
  - Grant order is 0,1,2,3.
  - Re-raising 0 and 3 together after 3 is granted gives order 0 then 3.
- **Slave error:** read with PSLVERR=1 at PREADY → `rsp_err`=1, PRDATA still captured.
- **Watchdog:** TIMEOUT=16, PREADY held low.
  - Exactly 16 ACCESS cycles, then PSEL=0.
  - `rsp_valid` pulse with `rsp_err`=1 and `rsp_rdata`=0.
  - A following request is granted normally.
- **Reset mid-ACCESS:** PRESET=1 while waiting.
  - PSEL, PENABLE and all outputs go to 0 before the next edge.
  - No `rsp_valid`.
  - After release, requester 0 has priority.

Source files
------------

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters,
// with an optional PREADY watchdog that aborts transfers to a hung slave.
module apb_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [AW-1:0]    PADDR,
  output logic [DW-1:0]    PWDATA,
  input  logic [DW-1:0]    PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] gnt;
  logic [IW-1:0] cand;
  logic          any;
  logic [CW-1:0] wait_cnt;
  logic          expired;

  // Walk downward so the candidate nearest last+1 is the one left standing.
  always_comb begin
    any  = 1'b0;
    gnt  = last;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req_valid[cand]) begin
        any = 1'b1;
        gnt = cand;
      end
    end
  end

  assign expired = (TIMEOUT != 0) && (wait_cnt == LIMIT);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      wait_cnt  <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            last      <= gnt;
            PADDR     <= req_addr[int'(gnt)*AW +: AW];
            PWDATA    <= req_wdata[int'(gnt)*DW +: DW];
            PWRITE    <= req_write[gnt];
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            req_ready <= NREQ'(1) << gnt;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NREQ'(1) << last;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state     <= IDLE;
          end else if (expired) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NREQ'(1) << last;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
